// File: rtl/sn76489_mix_sequencer_if.sv
// sn76489_mix_sequencer_if: register-write, attenuator and mix-output signals of the mix sequencer
interface sn76489_mix_sequencer_if;
  logic       sample_stb_i;
  logic       wr_i;
  logic [1:0] wr_ch_i;
  logic [3:0] wr_att_i;
  logic [3:0] level_i;
  logic [3:0] atten_sel_o;
  logic       factor_o;
  logic [7:0] product_i;
  logic [8:0] mix_o;
  logic       mix_vld_o;
  logic       busy_o;
  logic       overrun_o;
  logic       clr_ovr_i;
  modport slave (
    input  sample_stb_i, wr_i, wr_ch_i, wr_att_i, level_i, product_i, clr_ovr_i,
    output atten_sel_o, factor_o, mix_o, mix_vld_o, busy_o, overrun_o
  );
  modport master (
    output sample_stb_i, wr_i, wr_ch_i, wr_att_i, level_i, product_i, clr_ovr_i,
    input  atten_sel_o, factor_o, mix_o, mix_vld_o, busy_o, overrun_o
  );
endinterface

// File: rtl/sn76489_mix_sequencer.sv
// sn76489_mix_sequencer: walks the channels through one shared attenuator and sums the products into a mixed sample.
// Define SN76489_MIX_SIGNED_EN for a bipolar (two's complement) mix; the default build produces a unipolar mix.
module sn76489_mix_sequencer #(
  parameter int NUM_CH = 4
) (
  input logic                    clock_i,
  input logic                    res_i,
  sn76489_mix_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d, ch_q, ch_d;
  logic [3:0] att_q [4];
  logic [3:0] satt_q [4];
  logic [3:0] slev_q;
  logic [8:0] acc_q, acc_d, mix_q, mix_d, contrib;
  logic       ovr_q, ovr_d, last, accept, lev;
  always_comb begin
    lev     = slev_q[ch_q];
    last    = ch_q == 2'(NUM_CH - 1);
    accept  = state_q == IDLE && bus.sample_stb_i;
`ifdef SN76489_MIX_SIGNED_EN
    contrib = lev ? {1'b0, bus.product_i} : -{1'b0, bus.product_i};
`else
    contrib = lev ? {1'b0, bus.product_i} : 9'd0;
`endif
    state_d = accept ? RUN : (state_q == RUN && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
    ch_d    = state_q == RUN ? ch_q + 2'd1 : 2'd0;
    acc_d   = state_q == RUN ? acc_q + contrib : 9'd0;
    // the final sum lands in mix_q on the last RUN edge so it is already valid during DONE
    mix_d   = (state_q == RUN && last) ? acc_d : mix_q;
    ovr_d   = (bus.sample_stb_i && state_q != IDLE) ? 1'b1 : bus.clr_ovr_i ? 1'b0 : ovr_q;
  end
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      acc_q   <= 9'd0;
      mix_q   <= 9'd0;
      ovr_q   <= 1'b0;
      slev_q  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        att_q[i]  <= 4'hF;
        satt_q[i] <= 4'hF;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      ovr_q   <= ovr_d;
      if (bus.wr_i && int'(bus.wr_ch_i) < NUM_CH) att_q[bus.wr_ch_i] <= bus.wr_att_i;
      if (accept) begin
        satt_q <= att_q;
        slev_q <= bus.level_i;
      end
    end
  end
  assign bus.atten_sel_o = state_q == RUN ? satt_q[ch_q] : 4'hF;
`ifdef SN76489_MIX_SIGNED_EN
  assign bus.factor_o    = state_q == RUN;
`else
  assign bus.factor_o    = state_q == RUN && lev;
`endif
  assign bus.mix_o       = mix_q;
  assign bus.mix_vld_o   = state_q == DONE;
  assign bus.busy_o      = state_q != IDLE;
  assign bus.overrun_o   = ovr_q;
endmodule

// File: tb/tb_sn76489_mix_sequencer.sv
// tb_sn76489_mix_sequencer: vector table plus scoreboard for the mix sequencer, with hand-written overrun/snapshot/reset sequences
module tb_sn76489_mix_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sn76489_mix_sequencer_if b4 ();
  sn76489_mix_sequencer_if b3 ();
  sn76489_mix_sequencer #(.NUM_CH(4)) dut4 (.clock_i(clk), .res_i(rst), .bus(b4.slave));
  sn76489_mix_sequencer #(.NUM_CH(3)) dut3 (.clock_i(clk), .res_i(rst), .bus(b3.slave));

  logic [7:0] tbl [16] = '{8'd31, 8'd25, 8'd20, 8'd16, 8'd12, 8'd10, 8'd8, 8'd6,
                           8'd5, 8'd4, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
  assign b4.product_i = b4.factor_o ? tbl[b4.atten_sel_o] : 8'd0;
  assign b3.product_i = b3.factor_o ? tbl[b3.atten_sel_o] : 8'd0;

  typedef struct packed {
    logic [15:0] att;
    logic [3:0]  lev;
    logic [8:0]  exp;
  } vec_t;
  vec_t vecs [5];

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q [$];
  logic [8:0] sb_exp;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b4.mix_vld_o) begin
      if (exp_q.size() == 0) check("spurious_vld", 1, 0);
      else begin
        sb_exp = exp_q.pop_front();
        check("mix", int'(b4.mix_o), int'(sb_exp));
      end
    end
  end

  task automatic wr4(input logic [1:0] ch, input logic [3:0] v);
    @(negedge clk);
    b4.wr_i = 1'b1; b4.wr_ch_i = ch; b4.wr_att_i = v;
    @(negedge clk);
    b4.wr_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!b4.busy_o && exp_q.size() == 0) break;
    end
    check("drain", int'(b4.busy_o) + exp_q.size(), 0);
  endtask

  task automatic run_pass(input logic [15:0] att, input logic [3:0] lev, input logic [8:0] req);
    int n;
    n = 0;
    @(negedge clk);
    b4.level_i = lev; b4.sample_stb_i = 1'b1;
    exp_q.push_back(req);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      b4.sample_stb_i = 1'b0;
      if (i <= 4) check("atten_sel_seq", int'(b4.atten_sel_o), int'(att[4*(i-1) +: 4]));
      if (b4.mix_vld_o) begin
        n = i;
        break;
      end
    end
    check("latency", n, 5);
    check("sel_after_run", int'(b4.atten_sel_o), 15);
    @(negedge clk);
    check("busy_after_done", int'(b4.busy_o), 0);
    check("vld_pulse_width", int'(b4.mix_vld_o), 0);
  endtask

  initial begin
    int n;
    b4.sample_stb_i = 0; b4.wr_i = 0; b4.wr_ch_i = 0; b4.wr_att_i = 0; b4.level_i = 0; b4.clr_ovr_i = 0;
    b3.sample_stb_i = 0; b3.wr_i = 0; b3.wr_ch_i = 0; b3.wr_att_i = 0; b3.level_i = 0; b3.clr_ovr_i = 0;
`ifdef SN76489_MIX_SIGNED_EN
    vecs[0] = '{16'h0000, 4'hF, 9'd124};
    vecs[1] = '{16'h0000, 4'b0011, 9'd0};
    vecs[2] = '{16'h0000, 4'b0000, 9'h184};
    vecs[3] = '{16'hF420, 4'b0111, 9'd63};
    vecs[4] = '{16'h7531, 4'b1010, 9'h1F3};
`else
    vecs[0] = '{16'h0000, 4'hF, 9'd124};
    vecs[1] = '{16'hF420, 4'b0111, 9'd63};
    vecs[2] = '{16'hF420, 4'b0000, 9'd0};
    vecs[3] = '{16'h7531, 4'b1010, 9'd22};
    vecs[4] = '{16'hFFFF, 4'hF, 9'd0};
`endif
    repeat (3) @(negedge clk);
    check("rst_mix", int'(b4.mix_o), 0);
    check("rst_vld", int'(b4.mix_vld_o), 0);
    check("rst_busy", int'(b4.busy_o), 0);
    check("rst_ovr", int'(b4.overrun_o), 0);
    check("rst_sel", int'(b4.atten_sel_o), 15);
    check("rst_factor", int'(b4.factor_o), 0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int k = 0; k < 4; k++) wr4(2'(k), vecs[v].att[4*k +: 4]);
      run_pass(vecs[v].att, vecs[v].lev, vecs[v].exp);
    end

    for (int k = 0; k < 4; k++) wr4(2'(k), 4'h0);
    b4.level_i = 4'hF;
    @(negedge clk); b4.sample_stb_i = 1'b1; exp_q.push_back(9'd124);
    @(negedge clk); b4.sample_stb_i = 1'b0;
    @(negedge clk); b4.sample_stb_i = 1'b1;
    @(negedge clk); b4.sample_stb_i = 1'b0;
    check("overrun_set", int'(b4.overrun_o), 1);
    wait_idle();
    check("overrun_sticky", int'(b4.overrun_o), 1);
    @(negedge clk); b4.clr_ovr_i = 1'b1;
    @(negedge clk); b4.clr_ovr_i = 1'b0;
    check("overrun_clr", int'(b4.overrun_o), 0);
    @(negedge clk); b4.sample_stb_i = 1'b1; exp_q.push_back(9'd124);
    @(negedge clk); b4.sample_stb_i = 1'b0;
    @(negedge clk); b4.sample_stb_i = 1'b1; b4.clr_ovr_i = 1'b1;
    @(negedge clk); b4.sample_stb_i = 1'b0; b4.clr_ovr_i = 1'b0;
    check("overrun_set_wins", int'(b4.overrun_o), 1);
    wait_idle();
    @(negedge clk); b4.clr_ovr_i = 1'b1;
    @(negedge clk); b4.clr_ovr_i = 1'b0;

    wr4(2'd1, 4'hF);
    @(negedge clk);
    b4.sample_stb_i = 1'b1; b4.wr_i = 1'b1; b4.wr_ch_i = 2'd1; b4.wr_att_i = 4'h0;
    exp_q.push_back(9'd93);
    @(negedge clk);
    b4.sample_stb_i = 1'b0; b4.wr_i = 1'b0; b4.level_i = 4'h0;
    wait_idle();
    run_pass(16'h0000, 4'hF, 9'd124);

    @(negedge clk); b4.sample_stb_i = 1'b1;
    @(negedge clk); b4.sample_stb_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort_mix", int'(b4.mix_o), 0);
    check("abort_vld", int'(b4.mix_vld_o), 0);
    check("abort_busy", int'(b4.busy_o), 0);
    check("abort_sel", int'(b4.atten_sel_o), 15);
    check("abort_factor", int'(b4.factor_o), 0);
    check("abort_ovr", int'(b4.overrun_o), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_pass(16'hFFFF, 4'hF, 9'd0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b3.wr_i = 1'b1; b3.wr_ch_i = 2'(k); b3.wr_att_i = k == 3 ? 4'hF : 4'h0;
    end
    @(negedge clk);
    b3.wr_i = 1'b0; b3.level_i = 4'hF; b3.sample_stb_i = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      b3.sample_stb_i = 1'b0;
      if (b3.mix_vld_o) begin
        n = i;
        break;
      end
    end
    check("ch3_latency", n, 4);
    check("ch3_mix", int'(b3.mix_o), 93);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
